// File: rtl/control_sequencer.sv
// Control sequencer for the single-bus datapath: fetches via T0-T2, then
// executes ALU, multiply/divide, no-op and halt instructions in T3-T6.
module control_sequencer #(
    parameter int ICOUNT_W = 16
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [4:0]          Operator,
    output logic                Run,
    output logic [ICOUNT_W-1:0] icount
);

    typedef enum logic [3:0] {
        RST,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALT
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic       is_alu;
    logic       is_muldiv;
    logic       is_halt;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01101);
    assign is_muldiv = (opcode == 5'b01110) || (opcode == 5'b01111);
    assign is_halt   = (opcode == 5'b11011);
    assign unused_ir = ^ir[26:0];

    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= RST;
            icount <= '0;
        end else begin
            if (state == T0) begin
                icount <= icount + ICOUNT_W'(1);
            end
            case (state)
                RST:     state <= T0;
                T0:      state <= T1;
                T1:      state <= T2;
                T2:      state <= T3;
                T3: begin
                    if (is_alu || is_muldiv) begin
                        state <= T4;
                    end else if (is_halt) begin
                        state <= HALT;
                    end else begin
                        state <= T0;
                    end
                end
                T4:      state <= T5;
                T5:      state <= is_muldiv ? T6 : T0;
                T6:      state <= T0;
                HALT:    state <= HALT;
                default: state <= RST;
            endcase
        end
    end

    // Decoded from the state register and the live ir: IR is loaded on the
    // very edge that enters T3, so a pre-registered decode would see the
    // previous instruction during T3.
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        Operator = 5'b00000;
        Run      = (state != RST) && (state != HALT);
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu || is_muldiv) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                Grc      = 1'b1;
                Rout     = 1'b1;
                Zin      = 1'b1;
                Operator = opcode;
            end
            // Low half of a product/quotient goes to LO; otherwise Z returns to rA.
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table of instructions plus
// hand-written halt, mid-instruction clear and counter wrap sequences.
module tb_control_sequencer;

    // Strobe vector order [18:0]: PCout Zlowout Zhighout MDRout MARin Zin PCin
    // MDRin IRin Yin HIin LOin IncPC Read Gra Grb Grc Rin Rout
    localparam logic [18:0] E_NONE  = 19'b000_0000_0000_0000_0000;
    localparam logic [18:0] E_T0    = 19'b100_0110_0000_0100_0000;
    localparam logic [18:0] E_T1    = 19'b010_0001_1000_0010_0000;
    localparam logic [18:0] E_T2    = 19'b000_1000_0100_0000_0000;
    localparam logic [18:0] E_T3X   = 19'b000_0000_0010_0000_1001;
    localparam logic [18:0] E_T4    = 19'b000_0010_0000_0000_0101;
    localparam logic [18:0] E_T5ALU = 19'b010_0000_0000_0001_0010;
    localparam logic [18:0] E_T5MD  = 19'b010_0000_0000_1000_0000;
    localparam logic [18:0] E_T6    = 19'b001_0000_0001_0000_0000;

    localparam int C_NOP  = 0;
    localparam int C_ALU  = 1;
    localparam int C_MD   = 2;
    localparam int C_HALT = 3;

    typedef struct {
        string      name;
        logic [18:0] str;
        logic [4:0] op;
        logic       run;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        int          cls;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic [18:0] str;
    logic [4:0]  Operator;
    logic        Run;
    logic [15:0] icount;
    logic [18:0] n_str;
    logic [4:0]  n_op;
    logic        n_run;
    logic [3:0]  n_icount;

    exp_t        sb[$];
    vec_t        tbl[8];
    logic [15:0] exp_icount;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clear(clear), .ir(ir),
        .PCout(str[18]), .Zlowout(str[17]), .Zhighout(str[16]), .MDRout(str[15]),
        .MARin(str[14]), .Zin(str[13]), .PCin(str[12]), .MDRin(str[11]),
        .IRin(str[10]), .Yin(str[9]), .HIin(str[8]), .LOin(str[7]),
        .IncPC(str[6]), .Read(str[5]), .Gra(str[4]), .Grb(str[3]),
        .Grc(str[2]), .Rin(str[1]), .Rout(str[0]),
        .Operator(Operator), .Run(Run), .icount(icount)
    );

    // Narrow-counter copy so the wrap-around is reached within a short run.
    control_sequencer #(.ICOUNT_W(4)) dut_narrow (
        .clk(clk), .clear(clear), .ir(ir),
        .PCout(n_str[18]), .Zlowout(n_str[17]), .Zhighout(n_str[16]), .MDRout(n_str[15]),
        .MARin(n_str[14]), .Zin(n_str[13]), .PCin(n_str[12]), .MDRin(n_str[11]),
        .IRin(n_str[10]), .Yin(n_str[9]), .HIin(n_str[8]), .LOin(n_str[7]),
        .IncPC(n_str[6]), .Read(n_str[5]), .Gra(n_str[4]), .Grb(n_str[3]),
        .Grc(n_str[2]), .Rin(n_str[1]), .Rout(n_str[0]),
        .Operator(n_op), .Run(n_run), .icount(n_icount)
    );

    task automatic pushExp(input string name, input logic [18:0] s, input logic [4:0] op,
                           input logic run);
        exp_t e;
        e.name = name;
        e.str  = s;
        e.op   = op;
        e.run  = run;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got str=%b op=%b run=%b, no expected entry",
                     str, Operator, Run);
            return;
        end
        e = sb.pop_front();
        if (str !== e.str || Operator !== e.op || Run !== e.run) begin
            errors++;
            $display("[TB] FAIL %s: got str=%b op=%b run=%b, required str=%b op=%b run=%b",
                     e.name, str, Operator, Run, e.str, e.op, e.run);
        end
    endtask

    task automatic checkIcount(input string name);
        checks++;
        if (icount !== exp_icount || n_icount !== exp_icount[3:0]) begin
            errors++;
            $display("[TB] FAIL %s icount: got %h/%h, required %h/%h",
                     name, icount, n_icount, exp_icount, exp_icount[3:0]);
        end
    endtask

    // Entered at a negedge while in T0; leaves at the negedge after the last state.
    task automatic applyStimulus(input vec_t v);
        logic [4:0] op;
        int         n;
        op = v.ir[31:27];
        ir = v.ir;
        pushExp({v.name, " T0"}, E_T0, 5'b0, 1'b1);
        pushExp({v.name, " T1"}, E_T1, 5'b0, 1'b1);
        pushExp({v.name, " T2"}, E_T2, 5'b0, 1'b1);
        case (v.cls)
            C_ALU: begin
                pushExp({v.name, " T3"}, E_T3X, 5'b0, 1'b1);
                pushExp({v.name, " T4"}, E_T4, op, 1'b1);
                pushExp({v.name, " T5"}, E_T5ALU, 5'b0, 1'b1);
                n = 6;
            end
            C_MD: begin
                pushExp({v.name, " T3"}, E_T3X, 5'b0, 1'b1);
                pushExp({v.name, " T4"}, E_T4, op, 1'b1);
                pushExp({v.name, " T5"}, E_T5MD, 5'b0, 1'b1);
                pushExp({v.name, " T6"}, E_T6, 5'b0, 1'b1);
                n = 7;
            end
            default: begin
                pushExp({v.name, " T3"}, E_NONE, 5'b0, 1'b1);
                n = 4;
            end
        endcase
        for (int c = 0; c < n; c++) begin
            checkOutput();
            @(negedge clk);
        end
        exp_icount = exp_icount + 16'd1;
        checkIcount(v.name);
    endtask

    initial begin
        vec_t v;
        clear      = 1'b1;
        ir         = 32'h0;
        exp_icount = 16'h0;
        tbl[0] = '{32'h18000000, C_ALU, "alu 00011"};
        tbl[1] = '{32'h68000000, C_ALU, "alu 01101"};
        tbl[2] = '{32'h38000000, C_ALU, "alu 00111"};
        tbl[3] = '{32'h72920000, C_MD,  "mul"};
        tbl[4] = '{32'h78000000, C_MD,  "div"};
        tbl[5] = '{32'hD0000000, C_NOP, "nop 11010"};
        tbl[6] = '{32'h10000000, C_NOP, "nop 00010"};
        tbl[7] = '{32'h80000000, C_NOP, "nop 10000"};

        repeat (2) @(negedge clk);
        pushExp("reset", E_NONE, 5'b0, 1'b0);
        checkOutput();
        checkIcount("reset");
        clear = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) applyStimulus(tbl[i]);

        for (int k = 0; k < 12; k++) begin
            applyStimulus(tbl[5]);
        end

        // Clear lands in T4 of a multiply: no LO/HI writeback for it.
        ir = 32'h72920000;
        pushExp("mul-clr T0", E_T0, 5'b0, 1'b1);
        pushExp("mul-clr T1", E_T1, 5'b0, 1'b1);
        pushExp("mul-clr T2", E_T2, 5'b0, 1'b1);
        pushExp("mul-clr T3", E_T3X, 5'b0, 1'b1);
        pushExp("mul-clr T4", E_T4, 5'b01110, 1'b1);
        for (int c = 0; c < 4; c++) begin
            checkOutput();
            @(negedge clk);
        end
        checkOutput();
        clear = 1'b1;
        @(negedge clk);
        exp_icount = 16'h0;
        pushExp("mul-clr RST", E_NONE, 5'b0, 1'b0);
        checkOutput();
        checkIcount("mul-clr RST");
        clear = 1'b0;
        @(negedge clk);
        pushExp("mul-clr next T0", E_T0, 5'b0, 1'b1);
        checkOutput();

        applyStimulus(tbl[0]);
        v = '{32'hD8000000, C_HALT, "halt"};
        applyStimulus(v);
        for (int c = 0; c < 20; c++) begin
            pushExp("halt hold", E_NONE, 5'b0, 1'b0);
            checkOutput();
            @(negedge clk);
        end
        checkIcount("halt hold");

        clear = 1'b1;
        @(negedge clk);
        exp_icount = 16'h0;
        pushExp("halt-clr RST", E_NONE, 5'b0, 1'b0);
        checkOutput();
        checkIcount("halt-clr RST");
        clear = 1'b0;
        @(negedge clk);
        applyStimulus(tbl[3]);
        pushExp("after mul T0", E_T0, 5'b0, 1'b1);
        checkOutput();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock shared with the datapath.
REQ-003 clear  input  1  synchronous, active-high reset.
REQ-004 ir  input  32  current IR contents; opcode = ir[31:27].
REQ-005 PCout, Zlowout, Zhighout, MDRout  output  1 each  datapath bus-drive enables.
REQ-006 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  output  1 each  datapath register load enables.
REQ-007 IncPC, Read  output  1 each  PC-increment ALU select; memory read strobe.
REQ-008 Gra, Grb, Grc  output  1 each  selects the ir ra, rb or rc field for the register select/encode logic.
REQ-009 Rin, Rout  output  1 each  load/drive strobe for the GPR selected by Gra/Grb/Grc.
REQ-010 Operator  output  5  ALU operation code.
REQ-011 Run  output  1  high while the sequencer is fetching or executing.
REQ-012 icount  output  16  count of instruction fetches started.

Function
REQ-013 The FSM SHALL have the states RST, T0, T1, T2, T3, T4, T5, T6 and HALT, and each state SHALL last exactly one clk cycle.
REQ-014 RST SHALL go to T0; T0 SHALL go to T1; T1 SHALL go to T2; T2 SHALL go to T3.
REQ-015 Outputs SHALL be a Moore decode of the state and ir[31:27], and every output not listed for a state SHALL be 0.
REQ-016 T0 SHALL assert PCout, MARin, IncPC and Zin.
REQ-017 T1 SHALL assert Zlowout, PCin, Read and MDRin.
REQ-018 T2 SHALL assert MDRout and IRin; IR is loaded at the T2->T3 edge.
REQ-019 Opcode classes SHALL be: ALU = 00011..01101; MULDIV = 01110 (mul) and 01111 (div); HALT = 11011; any other opcode is treated as a no-op.
REQ-020 T3 for ALU or MULDIV opcodes SHALL assert Grb, Rout and Yin, then go to T4.
REQ-021 T3 for a no-op SHALL assert nothing and go to T0.
REQ-022 T3 for HALT SHALL assert nothing and go to HALT.
REQ-023 T4 SHALL assert Grc, Rout and Zin, with Operator = ir[31:27]; Operator SHALL be 00000 in every other state.
REQ-024 T5 for ALU opcodes SHALL assert Zlowout, Gra and Rin, then go to T0.
REQ-025 T5 for MULDIV opcodes SHALL assert Zlowout and LOin, then go to T6.
REQ-026 T6 SHALL assert Zhighout and HIin, then go to T0.
REQ-027 The opcode SHALL be sampled from ir in every state T3..T6; ir is stable from T3 through T6 because IRin is low.
REQ-028 HALT SHALL hold with all strobes low and Run = 0 until clear.
REQ-029 Run SHALL be 0 in RST and HALT, and 1 in all other states.
REQ-030 icount SHALL increment by 1 on each clk edge that leaves T0.
REQ-031 icount SHALL wrap from FFFF to 0000 without any flag.
REQ-032 Per-instruction latency SHALL be: ALU 6 cycles (T0-T5); MULDIV 7 cycles (T0-T6); no-op 4 cycles (T0-T3).

Reset
REQ-033 While clear = 1 at a rising edge, the state SHALL become RST and icount SHALL become 0, from any state including mid-instruction and HALT.
REQ-034 In RST, all outputs SHALL be 0, Run = 0 and Operator = 00000.
REQ-035 After clear is released, the first T0 SHALL occur exactly one cycle after RST.
REQ-036 The block SHALL have no asynchronous reset path.

Verification
REQ-037 Release clear, then supply ir = 72920000 (mul R5,R2,R4) from T3 onward -> states T0..T6 in sequence; T4 drives Operator = 01110 with Grc, Rout and Zin; T5 asserts LOin; T6 asserts HIin; icount = 1; then back to T0.
REQ-038 ALU opcode 00011 -> T5 asserts Gra, Rin and Zlowout; T6 never entered; the next T0 occurs 6 cycles after the previous T0.
REQ-039 Opcode 11010 (no-op) -> T3 has all strobes low; T0 follows immediately; icount increments once per 4 cycles.
REQ-040 Opcode 11011 (HALT) -> Run falls at HALT entry; 20 further cycles show no strobes and icount unchanged; then clear = 1 for 1 cycle -> RST, icount = 0, T0 one cycle after release.
REQ-041 clear asserted during T4 of a mul -> next state RST; HIin and LOin never asserted for that instruction; all outputs 0 during RST.
REQ-042 Preset icount = FFFF by running 65535 no-op instructions, then one more fetch -> icount = 0000 with no other effect.
